// File: rtl/ibuffer_mw_pkg.sv
// rtl/ibuffer_mw_pkg.sv - shared types, widths and helpers for the multi-wide instruction buffer
//
// Package ibuf_pkg
//   INST_W       : instruction width
//   PC_W_DEF     : default stored PC width
//   ibuf_entry_t : one buffered instruction with its PC (default PC width)
//   ptr_w()      : pointer width for a power-of-two depth
//   cnt_w()      : occupancy width able to hold 0..depth
package ibuf_pkg;

  localparam int INST_W   = 32;
  localparam int PC_W_DEF = 48;

  typedef struct packed {
    logic [INST_W-1:0]   inst;
    logic [PC_W_DEF-1:0] pc;
  } ibuf_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ibuffer_mw_if.sv
// rtl/ibuffer_mw_if.sv - fetch/dequeue/control bundle of the multi-wide instruction buffer
//
// Signals
//   fetch_valid/fetch_data/fetch_pc/fetch_ready : whole-line enqueue handshake
//   can_fetch/fetch_req                          : refill request path
//   flush/stall                                  : redirect clear, backend stall
//   deq_valid/deq_inst/deq_pc/deq_ready          : DEQ_W-lane dequeue, oldest in lane 0
//   count/empty                                  : occupancy
// Modports
//   slave  : the buffer
//   master : the environment driving fetch and consuming dequeue lanes
interface ibuffer_mw_if #(
  parameter int FETCH_W = 2,
  parameter int DEPTH   = 32,
  parameter int DEQ_W   = 2,
  parameter int PC_W    = ibuf_pkg::PC_W_DEF
);
  import ibuf_pkg::*;

  localparam int CNT_W = cnt_w(DEPTH);

  logic                      fetch_valid;
  logic [FETCH_W*INST_W-1:0] fetch_data;
  logic [63:0]               fetch_pc;
  logic                      fetch_ready;
  logic                      can_fetch;
  logic                      fetch_req;
  logic                      flush;
  logic                      stall;
  logic [DEQ_W-1:0]          deq_valid;
  logic [DEQ_W*INST_W-1:0]   deq_inst;
  logic [DEQ_W*PC_W-1:0]     deq_pc;
  logic [DEQ_W-1:0]          deq_ready;
  logic [CNT_W-1:0]          count;
  logic                      empty;

  modport slave (
    input  fetch_valid, fetch_data, fetch_pc, can_fetch, flush, stall, deq_ready,
    output fetch_ready, fetch_req, deq_valid, deq_inst, deq_pc, count, empty
  );

  modport master (
    output fetch_valid, fetch_data, fetch_pc, can_fetch, flush, stall, deq_ready,
    input  fetch_ready, fetch_req, deq_valid, deq_inst, deq_pc, count, empty
  );

endinterface

// File: rtl/ibuffer_mw_ram.sv
// rtl/ibuffer_mw_ram.sv - entry storage with FETCH_W wrapped write ports and DEQ_W async read ports
//
// Module ibuf_ram
//   i_clk   : clock
//   i_we    : write the whole line this cycle
//   i_waddr : address of lane 0; lane i lands at i_waddr+i modulo DEPTH
//   i_wdata : FETCH_W instructions
//   i_wpc   : FETCH_W stored PCs
//   i_raddr : address of read lane 0; lane k reads i_raddr+k modulo DEPTH
//   o_rinst : DEQ_W instructions (combinational)
//   o_rpc   : DEQ_W PCs (combinational)
module ibuf_ram
  import ibuf_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int FETCH_W = 2,
  parameter int DEQ_W   = 2,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
  input  logic [FETCH_W*INST_W-1:0] i_wdata,
  input  logic [FETCH_W*PC_W-1:0]   i_wpc,
  input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
  output logic [DEQ_W*INST_W-1:0]   o_rinst,
  output logic [DEQ_W*PC_W-1:0]     o_rpc
);
  localparam int PTR_W = ptr_w(DEPTH);

  // Data is never reset: occupancy alone decides which entries are meaningful.
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [PC_W-1:0]   r_pc   [DEPTH];

  // DEPTH is a power of two, so truncating the pointer sum wraps modulo DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < FETCH_W; i++) begin
        r_inst[i_waddr + PTR_W'(i)] <= i_wdata[i*INST_W +: INST_W];
        r_pc[i_waddr + PTR_W'(i)]   <= i_wpc[i*PC_W +: PC_W];
      end
    end
  end

  always_comb begin
    o_rinst = '0;
    o_rpc   = '0;
    for (int k = 0; k < DEQ_W; k++) begin
      o_rinst[k*INST_W +: INST_W] = r_inst[i_raddr + PTR_W'(k)];
      o_rpc[k*PC_W +: PC_W]       = r_pc[i_raddr + PTR_W'(k)];
    end
  end

endmodule

// File: rtl/ibuffer_mw.sv
// rtl/ibuffer_mw.sv - multi-wide instruction buffer between fetch and decode
//
// Ports
//   clock, reset_n      : clock, asynchronous active-low reset
//   bus (slave)         : fetch line in, DEQ_W-lane first-word-fall-through out,
//                         refill request, flush, stall, occupancy
//   perf_full_cycles    : cycles a line was offered but not accepted (IBUFFER_MW_PERF_EN only)
//   perf_flushed_insts  : instructions discarded by flushes (IBUFFER_MW_PERF_EN only)
// Build option
//   IBUFFER_MW_PERF_EN  : adds the two saturating 32-bit performance counters
module ibuffer_mw
  import ibuf_pkg::*;
#(
  parameter int FETCH_W   = 2,
  parameter int DEPTH     = 32,
  parameter int DEQ_W     = 2,
  parameter int PC_W      = PC_W_DEF,
  parameter int REFILL_WM = 4
) (
  input  logic        clock,
  input  logic        reset_n,
`ifdef IBUFFER_MW_PERF_EN
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_flushed_insts,
`endif
  ibuffer_mw_if.slave bus
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_count;
  logic                    r_req_pending;
  logic                    r_fetch_req;

  logic [CNT_W-1:0]        w_free;
  logic [CNT_W-1:0]        w_pops;
  logic [CNT_W-1:0]        w_count_next;
  logic                    w_fetch_ready;
  logic                    w_enq;
  logic                    w_req_cond;
  logic                    w_prefix;
  logic [DEQ_W-1:0]        w_deq_valid;
  logic [FETCH_W*PC_W-1:0] w_wpc;

  // Free space comes from the registered count only; a same-cycle pop does
  // not make room, which keeps fetch_ready off the consumer's timing path.
  assign w_free        = CNT_W'(DEPTH) - r_count;
  assign w_fetch_ready = (w_free >= CNT_W'(FETCH_W)) && !bus.flush;
  assign w_enq         = bus.fetch_valid && w_fetch_ready;

  // Lanes are offered oldest-first; only the leading run of accepted lanes
  // is consumed, so a gap in deq_ready stops the count there.
  always_comb begin
    w_deq_valid = '0;
    w_pops      = '0;
    w_prefix    = 1'b1;
    for (int k = 0; k < DEQ_W; k++) begin
      w_deq_valid[k] = (r_count > CNT_W'(k)) && !bus.stall && !bus.flush;
      w_prefix       = w_prefix && w_deq_valid[k] && bus.deq_ready[k];
      if (w_prefix) begin
        w_pops = w_pops + CNT_W'(1);
      end
    end
  end

  assign w_count_next = r_count + (w_enq ? CNT_W'(FETCH_W) : CNT_W'(0)) - w_pops;

  // Request only when a full line would fit and nothing is already in flight.
  assign w_req_cond = bus.can_fetch && !r_req_pending && !bus.flush &&
                      (r_count < CNT_W'(REFILL_WM)) && (w_free >= CNT_W'(FETCH_W));

  always_comb begin
    w_wpc = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      w_wpc[i*PC_W +: PC_W] = PC_W'(bus.fetch_pc + 64'(4 * i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_req_pending <= 1'b0;
      r_fetch_req   <= 1'b0;
    end else if (bus.flush) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_req_pending <= 1'b0;
      r_fetch_req   <= 1'b0;
    end else begin
      r_head      <= r_head + PTR_W'(w_pops);
      r_count     <= w_count_next;
      r_fetch_req <= w_req_cond;
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(FETCH_W);
      end
      // A line arriving in the same cycle a new request is raised answers
      // the previous request, not the new one.
      if (w_req_cond) begin
        r_req_pending <= 1'b1;
      end else if (w_enq) begin
        r_req_pending <= 1'b0;
      end
    end
  end

  ibuf_ram #(
    .DEPTH  (DEPTH),
    .FETCH_W(FETCH_W),
    .DEQ_W  (DEQ_W),
    .PC_W   (PC_W)
  ) u_ram (
    .i_clk  (clock),
    .i_we   (w_enq),
    .i_waddr(r_tail),
    .i_wdata(bus.fetch_data),
    .i_wpc  (w_wpc),
    .i_raddr(r_head),
    .o_rinst(bus.deq_inst),
    .o_rpc  (bus.deq_pc)
  );

  assign bus.fetch_ready = w_fetch_ready;
  assign bus.fetch_req   = r_fetch_req;
  assign bus.deq_valid   = w_deq_valid;
  assign bus.count       = r_count;
  assign bus.empty       = (r_count == '0);

`ifdef IBUFFER_MW_PERF_EN
  logic [31:0] r_perf_full;
  logic [31:0] r_perf_flushed;
  logic [32:0] w_flushed_sum;

  assign w_flushed_sum = {1'b0, r_perf_flushed} + 33'(r_count);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_full    <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (bus.fetch_valid && !w_fetch_ready && (r_perf_full != '1)) begin
        r_perf_full <= r_perf_full + 32'd1;
      end
      if (bus.flush) begin
        r_perf_flushed <= w_flushed_sum[32] ? '1 : w_flushed_sum[31:0];
      end
    end
  end

  assign perf_full_cycles   = r_perf_full;
  assign perf_flushed_insts = r_perf_flushed;
`endif

  for (genvar k = 1; k < DEQ_W; k++) begin : g_prefix_chk
    a_ready_prefix: assert property (@(posedge clock) disable iff (!reset_n)
      (w_deq_valid[k] && bus.deq_ready[k]) |-> bus.deq_ready[k-1]);
  end

  a_count_range: assert property (@(posedge clock) disable iff (!reset_n)
    r_count <= CNT_W'(DEPTH));

  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    w_pops <= r_count);

endmodule
